mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the memory address width.
REQ-002 Parameter REG_W, default 4, SHALL set the destination register index width.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in WAIT_R before a load aborts.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 valid_in  in  1  SHALL mark a valid instruction from execute.
REQ-007 mem_read, mem_write  in  1 each  SHALL flag a load or a store.
REQ-008 size  in  2  SHALL encode the access size: 00 byte, 01 half, 10 word; 11 is reserved.
REQ-009 sign_ext  in  1  SHALL select sign extension (1) or zero extension (0) for sub-word loads.
REQ-010 alu_result  in  32  SHALL carry the address or pass-through result; write_data in 32 SHALL carry the store data; rd_in in REG_W SHALL carry the destination register.
REQ-011 mem_req, mem_we  out  1 each; mem_addr out ADDR_W; mem_wdata out 32; mem_be out 4  SHALL form the memory request port.
REQ-012 mem_gnt, mem_rvalid  in  1 each; mem_rdata in 32  SHALL form the memory response port.
REQ-013 valid_out out 1; read_data out 32; alu_result_out out 32; rd_out out REG_W; err out 1  SHALL form the writeback port.
REQ-014 stall  out  1  SHALL tell upstream to hold its inputs.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT_R; stall SHALL equal (state != IDLE).
REQ-016 valid_in SHALL be sampled only in IDLE; alu_result, write_data, rd_in, size, sign_ext and the op flags SHALL be captured on acceptance.
REQ-017 Accepted non-memory op: valid_out=1 on the next cycle, alu_result_out and rd_out from the capture, read_data=0, no mem_req.
REQ-018 Error cases SHALL be: misaligned access (half with addr[0]=1, word with addr[1:0]!=0), size=11, or mem_read and mem_write both set; each SHALL produce valid_out=1 and err=1 on the next cycle, with no mem_req issued.
REQ-019 Accepted legal memory op: transition to REQ; mem_req=1 held in REQ, with mem_addr, mem_we, mem_be and mem_wdata stable until mem_gnt.
REQ-020 Store on mem_gnt: return to IDLE; valid_out=1 on the following cycle.
REQ-021 Load on mem_gnt: transition to WAIT_R; on mem_rvalid, return to IDLE; valid_out=1 on the following cycle with the extracted data.
REQ-022 mem_rvalid SHALL be ignored outside WAIT_R; mem_gnt SHALL be ignored outside REQ.
REQ-023 Byte lanes (little-endian): byte mem_be=1<<addr[1:0]; half mem_be=0011<<(2*addr[1]); word mem_be=1111.
REQ-024 mem_wdata SHALL replicate the low byte or halfword across all lanes for sub-word stores.
REQ-025 Loads SHALL select the addressed lane(s), then sign- or zero-extend per sign_ext; word loads SHALL pass unchanged.
REQ-026 The WAIT_R counter SHALL clear on entry and increment each cycle; on reaching TIMEOUT without mem_rvalid, the block SHALL return to IDLE and raise valid_out=1, err=1, read_data=0.
REQ-027 mem_rvalid arriving in the same cycle the counter reaches TIMEOUT SHALL win: data is returned and err=0.
REQ-028 valid_out SHALL be a one-cycle pulse; the other writeback outputs SHALL hold their value until the next valid_out.
REQ-029 Minimum latency: non-memory op 1 cycle; store 2 cycles (gnt in first REQ cycle); load 3 cycles (gnt and rvalid each on first opportunity).

Reset
REQ-030 On rst: state=IDLE, counter=0; all outputs 0, including mem_req and stall on the next cycle.
REQ-031 rst during REQ or WAIT_R SHALL abandon the transaction with no valid_out, and any later mem_rvalid SHALL be ignored.

Structure
REQ-032 Package mem_stage_pkg SHALL hold the size encoding enum, the FSM state enum and the constant LANES=4.
REQ-033 Combinational sub-module lsu_align SHALL implement byte-enable generation, store replication and load extraction/extension.

Verification
REQ-034 Non-memory op: alu_result=0x1234, rd_in=3 -> next cycle valid_out=1, alu_result_out=0x1234, rd_out=3, err=0.
REQ-035 Byte store: addr=0x102, write_data=0xAB, gnt after 2 REQ cycles -> mem_be=0100, mem_wdata=0xABABABAB, valid_out 1 cycle after gnt.
REQ-036 Half load: addr=0x202, sign_ext=1, rdata=0x8001_0000 -> read_data=0xFFFF8001; with sign_ext=0 -> 0x00008001.
REQ-037 Word load: addr=0x301 -> no mem_req; next cycle valid_out=1, err=1.
REQ-038 Load with TIMEOUT=4 and no rvalid -> err=1 after 4 WAIT_R cycles; a repeat with rvalid on cycle 4 -> err=0 and data returned.
REQ-039 rst asserted in WAIT_R, followed by a late rvalid -> no valid_out; stall=0 after reset.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory-stage load/store unit.
//   size_e  - access size encoding carried with each instruction
//   state_e - LSU control FSM states
//   LANES   - byte lanes on the 32-bit memory data bus
//   misaligned() - address alignment check for a given access size
package mem_stage_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10
  } state_e;

  // Bytes are always aligned; the reserved size is rejected separately.
  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (sz)
      SZ_HALF: m = a[0];
      SZ_WORD: m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-lane logic (little-endian) for the LSU.
//   size, addr_lo - access size and low address bits
//   sign_ext      - sign (1) or zero (0) extend sub-word loads
//   wdata         - raw store data; wdata_rep replicates the low byte/half
//   rdata         - raw bus read data; rdata_ext is the extracted, extended value
//   be            - byte enables for the access
module lsu_align import mem_stage_pkg::*; (
  input  size_e             size,
  input  logic [1:0]        addr_lo,
  input  logic              sign_ext,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic [LANES-1:0]  be,
  output logic [31:0]       wdata_rep,
  output logic [31:0]       rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = rdata[{addr_lo[1], 4'b0000} +: 16];
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      SZ_WORD: be = 4'b1111;
      default: be = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory pipeline stage. Accepts one instruction at a time
// from execute, issues at most one memory request, and retires a single
// valid_out pulse on the writeback port.
//   execute side : valid_in, mem_read, mem_write, size, sign_ext,
//                  alu_result, write_data, rd_in, stall (hold upstream)
//   memory side  : mem_req/mem_we/mem_addr/mem_wdata/mem_be out,
//                  mem_gnt/mem_rvalid/mem_rdata in
//   writeback    : valid_out, read_data, alu_result_out, rd_out, err
module mem_stage_lsu import mem_stage_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       write_data,
  input  logic [REG_W-1:0]  rd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              valid_out,
  output logic [31:0]       read_data,
  output logic [31:0]       alu_result_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              err,
  output logic              stall
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Captured instruction
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  size_e              size_q, size_d;
  logic               sext_q, sext_d;
  logic               store_q, store_d;

  // Writeback registers
  logic               vout_q, vout_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        alu_out_q, alu_out_d;
  logic [REG_W-1:0]   rd_out_q, rd_out_d;
  logic               err_q, err_d;

  logic [LANES-1:0]   be_w;
  logic [31:0]        wdata_rep_w;
  logic [31:0]        rdata_ext_w;

  size_e              size_in;
  logic               is_mem, bad_op;

  lsu_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .sign_ext  (sext_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be_w),
    .wdata_rep (wdata_rep_w),
    .rdata_ext (rdata_ext_w)
  );

  always_comb begin
    size_in = size_e'(size);
    is_mem  = mem_read | mem_write;
    bad_op  = (mem_read & mem_write) | (size_in == SZ_RSVD) |
              misaligned(size_in, alu_result[1:0]);

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    size_d    = size_q;
    sext_d    = sext_q;
    store_d   = store_q;
    vout_d    = 1'b0;
    rdata_d   = rdata_q;
    alu_out_d = alu_out_q;
    rd_out_d  = rd_out_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_in) begin
          addr_d  = alu_result;
          wdata_d = write_data;
          rd_d    = rd_in;
          size_d  = size_in;
          sext_d  = sign_ext;
          store_d = mem_write;
          if (!is_mem || bad_op) begin
            // Retire immediately; bad memory ops never reach the bus.
            vout_d    = 1'b1;
            err_d     = is_mem;
            rdata_d   = '0;
            alu_out_d = alu_result;
            rd_out_d  = rd_in;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (store_q) begin
            state_d   = IDLE;
            vout_d    = 1'b1;
            err_d     = 1'b0;
            rdata_d   = '0;
            alu_out_d = addr_q;
            rd_out_d  = rd_q;
          end else begin
            state_d = WAIT_R;
            cnt_d   = '0;
          end
        end
      end
      WAIT_R: begin
        // rvalid is checked first so it wins over the timeout cycle.
        if (mem_rvalid) begin
          state_d   = IDLE;
          vout_d    = 1'b1;
          err_d     = 1'b0;
          rdata_d   = rdata_ext_w;
          alu_out_d = addr_q;
          rd_out_d  = rd_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // cnt_q+1 reaches TIMEOUT here: TIMEOUT cycles spent waiting.
          state_d   = IDLE;
          vout_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          alu_out_d = addr_q;
          rd_out_d  = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      size_q    <= SZ_BYTE;
      sext_q    <= 1'b0;
      store_q   <= 1'b0;
      vout_q    <= 1'b0;
      rdata_q   <= '0;
      alu_out_q <= '0;
      rd_out_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      store_q   <= store_d;
      vout_q    <= vout_d;
      rdata_q   <= rdata_d;
      alu_out_q <= alu_out_d;
      rd_out_q  <= rd_out_d;
      err_q     <= err_d;
    end
  end

  // Request fields are driven from captured state, so they stay stable in REQ.
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & store_q;
    mem_addr  = ADDR_W'(addr_q);
    mem_be    = mem_req ? be_w : '0;
    mem_wdata = mem_we ? wdata_rep_w : '0;
    stall     = (state_q != IDLE);
  end

  assign valid_out      = vout_q;
  assign read_data      = rdata_q;
  assign alu_result_out = alu_out_q;
  assign rd_out         = rd_out_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic [31:0] alu_result, write_data;
  logic [3:0]  rd_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        valid_out, err, stall;
  logic [31:0] read_data, alu_result_out;
  logic [3:0]  rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .REG_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
    .alu_result(alu_result), .write_data(write_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .valid_out(valid_out),
    .read_data(read_data), .alu_result_out(alu_result_out), .rd_out(rd_out),
    .err(err), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] r);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    alu_result = a; write_data = wd; rd_in = r;
    tick();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Load with gnt in the first REQ cycle and rvalid in the first WAIT_R cycle.
  task automatic quick_load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                            input logic [31:0] rdat, input logic [3:0] r);
    issue(1'b1, 1'b0, sz, sx, a, 32'h0, r);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = rdat; tick(); mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 0; mem_read = 0; mem_write = 0; size = 0; sign_ext = 0;
    alu_result = 0; write_data = 0; rd_in = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);

    // Non-memory op
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 4'd3);
    chk("nm_valid", {31'b0, valid_out}, 32'd1);
    chk("nm_alu", alu_result_out, 32'h1234);
    chk("nm_rd", {28'b0, rd_out}, 32'd3);
    chk("nm_err", {31'b0, err}, 32'd0);
    chk("nm_rdata", read_data, 32'd0);
    chk("nm_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("nm_pulse", {31'b0, valid_out}, 32'd0);
    chk("nm_hold", alu_result_out, 32'h1234);

    // Byte store, gnt held off for two REQ cycles
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'hAB, 4'd5);
    chk("sb_req", {31'b0, mem_req}, 32'd1);
    chk("sb_we", {31'b0, mem_we}, 32'd1);
    chk("sb_addr", mem_addr, 32'h102);
    chk("sb_be", {28'b0, mem_be}, 32'h4);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("sb_req2", {31'b0, mem_req}, 32'd1);
    chk("sb_be2", {28'b0, mem_be}, 32'h4);
    chk("sb_novld", {31'b0, valid_out}, 32'd0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    chk("sb_valid", {31'b0, valid_out}, 32'd1);
    chk("sb_err", {31'b0, err}, 32'd0);
    chk("sb_rd", {28'b0, rd_out}, 32'd5);
    chk("sb_idle", {31'b0, stall}, 32'd0);

    // Half store replication, upper half
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h1234CDEF, 4'd1);
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCDEFCDEF);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;

    // Half loads: sign and zero extension
    quick_load(2'b01, 1'b1, 32'h202, 32'h8001_0000, 4'd7);
    chk("lh_s_valid", {31'b0, valid_out}, 32'd1);
    chk("lh_s_data", read_data, 32'hFFFF8001);
    chk("lh_s_rd", {28'b0, rd_out}, 32'd7);
    quick_load(2'b01, 1'b0, 32'h202, 32'h8001_0000, 4'd7);
    chk("lh_z_data", read_data, 32'h00008001);
    quick_load(2'b00, 1'b1, 32'h3, 32'h8000_0000, 4'd2);
    chk("lb_s_data", read_data, 32'hFFFFFF80);

    // Error cases: misaligned word, reserved size, read+write
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 4'd4);
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_valid", {31'b0, valid_out}, 32'd1);
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 4'd4);
    chk("rsv_err", {31'b0, err}, 32'd1);
    chk("rsv_req", {31'b0, mem_req}, 32'd0);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 4'd4);
    chk("rw_err", {31'b0, err}, 32'd1);

    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    chk("stray_rv", {31'b0, valid_out}, 32'd0);

    // Timeout: 4 WAIT_R cycles without rvalid
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 4'd6);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait", {30'b0, valid_out, stall}, 32'd1);
    end
    tick();
    chk("to_valid", {31'b0, valid_out}, 32'd1);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_rdata", read_data, 32'd0);
    chk("to_stall", {31'b0, stall}, 32'd0);

    // rvalid in the 4th WAIT_R cycle wins over the timeout
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 4'd6);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    tick(); tick(); tick();
    chk("tw_novld", {31'b0, valid_out}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEBABE; tick(); mem_rvalid = 1'b0;
    chk("tw_valid", {31'b0, valid_out}, 32'd1);
    chk("tw_err", {31'b0, err}, 32'd0);
    chk("tw_data", read_data, 32'hCAFEBABE);

    // Reset in WAIT_R, then a late rvalid
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 4'd9);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("wr_rst_stall", {31'b0, stall}, 32'd0);
    chk("wr_rst_vld", {31'b0, valid_out}, 32'd0);
    chk("wr_rst_alu", alu_result_out, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; tick(); mem_rvalid = 1'b0;
    chk("late_rv_vld", {31'b0, valid_out}, 32'd0);
    tick();
    chk("late_rv_vld2", {31'b0, valid_out}, 32'd0);
    chk("late_rv_data", read_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
